// File: rtl/rst_seq.sv
// Reset sequencer: decodes PLL lock, board reset, PU warm-reset request and
// the software cold/warm/poweroff codes into per-domain active-high resets.
// After a hold period, domains are released one at a time in index order.
module rst_seq #(
  parameter int DOMCNT    = 4,
  parameter int CNTRBITSZ = 8,
  parameter int HOLDCNT   = 15,
  parameter int GAPCNT    = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              locked_i,
  input  logic              swrst0_i,
  input  logic              swrst1_i,
  input  logic              hwrst_i,
  input  logic [DOMCNT-1:0] warmmask_i,
  output logic [DOMCNT-1:0] rst_o,
  output logic              gsr_o,
  output logic              pwroff_o,
  output logic              busy_o
);

  localparam int IDXW = (DOMCNT > 1) ? $clog2(DOMCNT) : 1;

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_REL    = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_PWROFF = 2'd3;

  localparam logic [CNTRBITSZ-1:0] HOLD_LD = CNTRBITSZ'(HOLDCNT);
  localparam logic [CNTRBITSZ-1:0] GAP_LD  = CNTRBITSZ'(GAPCNT);
  localparam logic [IDXW-1:0]      IDX_ONE = IDXW'(1);
  localparam logic [IDXW-1:0]      IDX_LST = IDXW'(DOMCNT - 1);
  // The first release after the hold goes straight to RUN for a single domain.
  localparam logic [1:0]           ST_AFTER_HOLD = (DOMCNT == 1) ? ST_RUN : ST_REL;

  logic [1:0]           r_state;
  logic [CNTRBITSZ-1:0] r_cntr;
  logic [IDXW-1:0]      r_idx;
  logic [DOMCNT-1:0]    r_rst;
  logic                 r_gsr;
  logic                 r_pwroff;

  logic w_cold, w_warm, w_pwroff;

  // Software/hardware request decode.
  always_comb begin
    w_cold   = swrst0_i & swrst1_i;
    w_warm   = (~swrst0_i & swrst1_i) | hwrst_i;
    w_pwroff = swrst0_i & ~swrst1_i;
  end

  // Sequencer: prioritised event handling, then hold/release counting.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_HOLD;
      r_cntr   <= HOLD_LD;
      r_idx    <= '0;
      r_rst    <= '1;
      r_gsr    <= 1'b0;
      r_pwroff <= 1'b0;
    end else begin
      r_gsr <= 1'b0;
      if (w_cold && r_state != ST_PWROFF) begin
        r_gsr   <= 1'b1;
        r_state <= ST_HOLD;
        r_cntr  <= HOLD_LD;
        r_idx   <= '0;
        r_rst   <= '1;
      end else if (w_pwroff) begin
        r_state  <= ST_PWROFF;
        r_rst    <= '1;
        r_pwroff <= 1'b1;
      end else if (r_state == ST_PWROFF) begin
        // Latched until board reset; lock, cold and warm are ignored here.
        r_rst <= '1;
      end else if (!locked_i) begin
        r_state <= ST_HOLD;
        r_cntr  <= HOLD_LD;
        r_idx   <= '0;
        r_rst   <= '1;
      end else if (w_warm) begin
        // Only masked domains are re-reset; others keep running.
        r_state <= ST_HOLD;
        r_cntr  <= HOLD_LD;
        r_idx   <= '0;
        r_rst   <= r_rst | warmmask_i;
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (r_cntr != '0) begin
              r_cntr <= r_cntr - 1'b1;
            end else begin
              r_rst[0] <= 1'b0;
              r_idx    <= IDX_ONE;
              r_cntr   <= GAP_LD;
              r_state  <= ST_AFTER_HOLD;
            end
          end
          ST_REL: begin
            if (r_cntr != '0) begin
              r_cntr <= r_cntr - 1'b1;
            end else begin
              r_rst[r_idx] <= 1'b0;
              r_cntr       <= GAP_LD;
              r_idx        <= r_idx + 1'b1;
              if (r_idx == IDX_LST) r_state <= ST_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs straight from registers; busy is combinational on state.
  always_comb begin
    rst_o    = r_rst;
    gsr_o    = r_gsr;
    pwroff_o = r_pwroff;
    busy_o   = (r_state != ST_RUN);
  end

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with DOMCNT=3, HOLDCNT=3, GAPCNT=2.
module tb_rst_seq;

  logic       clk_i = 1'b0;
  logic       rst_n_i, locked_i, swrst0_i, swrst1_i, hwrst_i;
  logic [2:0] warmmask_i;
  logic [2:0] rst_o;
  logic       gsr_o, pwroff_o, busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  rst_seq #(.DOMCNT(3), .CNTRBITSZ(8), .HOLDCNT(3), .GAPCNT(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .locked_i(locked_i),
    .swrst0_i(swrst0_i), .swrst1_i(swrst1_i), .hwrst_i(hwrst_i),
    .warmmask_i(warmmask_i), .rst_o(rst_o), .gsr_o(gsr_o),
    .pwroff_o(pwroff_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Expected rst_o e edges after a hold starts (e=0 is the edge loading HOLDCNT).
  function automatic logic [2:0] seq_exp(input int e);
    if (e < 4)       return 3'b111;
    else if (e < 7)  return 3'b110;
    else if (e < 10) return 3'b100;
    else             return 3'b000;
  endfunction

  task automatic do_reset();
    rst_n_i = 1'b0;
    tick(2);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    locked_i = 1'b1; swrst0_i = 1'b0; swrst1_i = 1'b0;
    hwrst_i = 1'b0; warmmask_i = 3'b000;
    do_reset();
    n_chk++; if (rst_o !== 3'b111) begin n_fail++; $display("FAIL reset_rst got=%b exp=111", rst_o); end
    n_chk++; if (gsr_o !== 1'b0)   begin n_fail++; $display("FAIL reset_gsr got=%b exp=0", gsr_o); end
    n_chk++; if (pwroff_o !== 1'b0) begin n_fail++; $display("FAIL reset_pwroff got=%b exp=0", pwroff_o); end
    n_chk++; if (busy_o !== 1'b1)  begin n_fail++; $display("FAIL reset_busy got=%b exp=1", busy_o); end
  endtask

  // Walks a full release sequence from edge 1 to edge 10 after a hold start.
  task automatic check_seq(input string nm);
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      n_chk++;
      if (rst_o !== seq_exp(e)) begin
        n_fail++; $display("FAIL %s_rst edge=%0d got=%b exp=%b", nm, e, rst_o, seq_exp(e));
      end
      n_chk++;
      if (busy_o !== (e < 10)) begin
        n_fail++; $display("FAIL %s_busy edge=%0d got=%b exp=%b", nm, e, busy_o, (e < 10));
      end
      n_chk++;
      if (gsr_o !== 1'b0) begin
        n_fail++; $display("FAIL %s_gsr edge=%0d got=%b exp=0", nm, e, gsr_o);
      end
    end
  endtask

  task automatic test_powerup();
    check_seq("powerup");
  endtask

  task automatic test_warm();
    logic [2:0] exp;
    warmmask_i = 3'b110;
    hwrst_i = 1'b1;
    tick(1);
    hwrst_i = 1'b0;
    n_chk++; if (rst_o !== 3'b110) begin n_fail++; $display("FAIL warm_assert got=%b exp=110", rst_o); end
    n_chk++; if (busy_o !== 1'b1)  begin n_fail++; $display("FAIL warm_busy got=%b exp=1", busy_o); end
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      exp = seq_exp(e) & 3'b110;
      n_chk++;
      if (rst_o !== exp) begin
        n_fail++; $display("FAIL warm_seq edge=%0d got=%b exp=%b", e, rst_o, exp);
      end
    end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL warm_done_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_cold();
    swrst0_i = 1'b1; swrst1_i = 1'b1;
    tick(1);
    swrst0_i = 1'b0; swrst1_i = 1'b0;
    n_chk++; if (gsr_o !== 1'b1)   begin n_fail++; $display("FAIL cold_gsr got=%b exp=1", gsr_o); end
    n_chk++; if (rst_o !== 3'b111) begin n_fail++; $display("FAIL cold_rst got=%b exp=111", rst_o); end
    check_seq("cold");
  endtask

  task automatic test_pwroff();
    swrst0_i = 1'b1; swrst1_i = 1'b0;
    tick(1);
    swrst0_i = 1'b0;
    n_chk++; if (rst_o !== 3'b111)  begin n_fail++; $display("FAIL pwroff_rst got=%b exp=111", rst_o); end
    n_chk++; if (pwroff_o !== 1'b1) begin n_fail++; $display("FAIL pwroff_flag got=%b exp=1", pwroff_o); end
    n_chk++; if (busy_o !== 1'b1)   begin n_fail++; $display("FAIL pwroff_busy got=%b exp=1", busy_o); end
    // cold, warm and lock activity must all be ignored
    swrst0_i = 1'b1; swrst1_i = 1'b1;
    tick(1);
    swrst0_i = 1'b0; swrst1_i = 1'b0;
    n_chk++; if (gsr_o !== 1'b0) begin n_fail++; $display("FAIL pwroff_cold_gsr got=%b exp=0", gsr_o); end
    hwrst_i = 1'b1; warmmask_i = 3'b111;
    tick(1);
    hwrst_i = 1'b0;
    locked_i = 1'b0;
    tick(2);
    locked_i = 1'b1;
    tick(6);
    n_chk++; if (rst_o !== 3'b111)  begin n_fail++; $display("FAIL pwroff_hold_rst got=%b exp=111", rst_o); end
    n_chk++; if (pwroff_o !== 1'b1) begin n_fail++; $display("FAIL pwroff_hold_flag got=%b exp=1", pwroff_o); end
    n_chk++; if (busy_o !== 1'b1)   begin n_fail++; $display("FAIL pwroff_hold_busy got=%b exp=1", busy_o); end
    rst_n_i = 1'b0;
    tick(1);
    rst_n_i = 1'b1;
    n_chk++; if (pwroff_o !== 1'b0) begin n_fail++; $display("FAIL pwroff_clear got=%b exp=0", pwroff_o); end
    check_seq("pwroff_restart");
  endtask

  task automatic test_lock_loss();
    do_reset();
    tick(4);
    n_chk++; if (rst_o !== 3'b110) begin n_fail++; $display("FAIL lock_pre got=%b exp=110", rst_o); end
    locked_i = 1'b0;
    for (int e = 5; e <= 9; e++) begin
      tick(1);
      n_chk++;
      if (rst_o !== 3'b111) begin n_fail++; $display("FAIL lock_low edge=%0d got=%b exp=111", e, rst_o); end
    end
    locked_i = 1'b1;
    for (int e = 10; e <= 13; e++) begin
      tick(1);
      n_chk++;
      if (rst_o !== ((e < 13) ? 3'b111 : 3'b110)) begin
        n_fail++; $display("FAIL lock_relock edge=%0d got=%b exp=%b", e, rst_o, (e < 13) ? 3'b111 : 3'b110);
      end
    end
  endtask

  task automatic test_warm_release();
    do_reset();
    tick(5);
    n_chk++; if (rst_o !== 3'b110) begin n_fail++; $display("FAIL wrel_pre got=%b exp=110", rst_o); end
    warmmask_i = 3'b111;
    hwrst_i = 1'b1;
    tick(1);
    hwrst_i = 1'b0;
    n_chk++; if (rst_o !== 3'b111) begin n_fail++; $display("FAIL wrel_assert got=%b exp=111", rst_o); end
    for (int e = 7; e <= 13; e++) begin
      tick(1);
      n_chk++;
      if (rst_o !== seq_exp(e - 6)) begin
        n_fail++; $display("FAIL wrel_seq edge=%0d got=%b exp=%b", e, rst_o, seq_exp(e - 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_warm();
    test_cold();
    test_pwroff();
    test_lock_loss();
    test_warm_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
